// File: rtl/pool_pkg.sv
// Shared types and sizes for the streamed 2x2 max-pooling engine.
package pool_pkg;

  localparam int DATA_W          = 16;
  localparam int POOL_FIFO_DEPTH = 8;

  typedef logic [DATA_W-1:0] pix_t;

endpackage

// File: rtl/fifo_mem.sv
// Register file: synchronous write port, asynchronous read port.
module fifo_mem
  import pool_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = POOL_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo.sv
// FWFT FIFO carrying partial row maxima between pooling stages.
module fifo
  import pool_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = POOL_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic                     read,
  input  logic [WIDTH-1:0]         output_to_fifo,
  output logic [WIDTH-1:0]         input_from_fifo,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is fine when the head leaves the same edge.
  assign w_push = write && (!w_full || read);
  assign w_pop  = read && !w_empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (output_to_fifo),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= write && w_full && !read;
      r_underflow <= read && w_empty;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  assign input_from_fifo = w_empty ? '0 : w_rdata;
  assign full            = w_full;
  assign empty           = w_empty;
  assign count           = r_count;
  assign overflow        = r_overflow;
  assign underflow       = r_underflow;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed vector table, then random traffic vs a queue model.
module tb_fifo;
  import pool_pkg::*;

  localparam int W  = DATA_W;
  localparam int D  = POOL_FIFO_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  pix_t          din = '0;
  pix_t          dout;
  logic          full, empty, ovf, udf;
  logic [CW-1:0] count;

  fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .write           (write),
    .read            (read),
    .output_to_fifo  (din),
    .input_from_fifo (dout),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (ovf),
    .underflow       (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, w, r;
    int d;
    int ed, ec;
    bit ef, ee, eo, eu;
  } vec_t;

  vec_t tab[$];
  int   n_vec = 0;
  int   n_bad = 0;

  pix_t q[$];
  bit   m_ovf, m_udf;

  function automatic void add(bit rst, bit w, bit r, int d,
                              int ed, int ec, bit ef, bit ee,
                              bit eo, bit eu);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.d = d;
    v.ed = ed; v.ec = ec; v.ef = ef; v.ee = ee;
    v.eo = eo; v.eu = eu;
    tab.push_back(v);
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus; the model follows the FIFO rules directly.
  task automatic step(bit rst, bit w, bit r, pix_t d);
    int sz;
    reset = rst; write = w; read = r; din = d;
    @(posedge clk);
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = w && (sz == D) && !r;
      m_udf = r && (sz == 0);
      if (r && sz > 0) void'(q.pop_front());
      if (w && (sz < D || r)) q.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(string tag);
    int sz;
    sz = q.size();
    cmp({tag, ".dout"},  32'(dout),  (sz > 0) ? 32'(q[0]) : 32'd0);
    cmp({tag, ".count"}, 32'(count), 32'(sz));
    cmp({tag, ".full"},  32'(full),  32'(sz == D));
    cmp({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    cmp({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    cmp({tag, ".udf"},   32'(udf),   32'(m_udf));
  endtask

  initial begin
    int drain_exp[8] = '{3, 4, 5, 6, 7, 8, 100, 0};

    // reset, idle, push 5/6/12/13, pop four
    add(1,0,0, 0,   0,0, 0,1, 0,0);
    add(0,0,0, 0,   0,0, 0,1, 0,0);
    add(0,1,0, 5,   5,1, 0,0, 0,0);
    add(0,1,0, 6,   5,2, 0,0, 0,0);
    add(0,1,0, 12,  5,3, 0,0, 0,0);
    add(0,1,0, 13,  5,4, 0,0, 0,0);
    add(0,0,1, 0,   6,3, 0,0, 0,0);
    add(0,0,1, 0,  12,2, 0,0, 0,0);
    add(0,0,1, 0,  13,1, 0,0, 0,0);
    add(0,0,1, 0,   0,0, 0,1, 0,0);
    // fill 1..8, overflow with 99, both while full
    for (int k = 1; k <= 8; k++)
      add(0,1,0, k, 1,k, k == 8,0, 0,0);
    add(0,1,0, 99,  1,8, 1,0, 1,0);
    add(0,0,0, 0,   1,8, 1,0, 0,0);
    add(0,1,1, 100, 2,8, 1,0, 0,0);
    for (int k = 1; k <= 8; k++)
      add(0,0,1, 0, drain_exp[k-1], 8-k, 0, k == 8, 0,0);
    // underflow, both while empty
    add(0,0,1, 0,   0,0, 0,1, 0,1);
    add(0,1,1, 7,   7,1, 0,0, 0,1);
    add(0,0,0, 0,   7,1, 0,0, 0,0);
    // reset with five entries plus a write
    for (int k = 2; k <= 5; k++)
      add(0,1,0, 19+k, 7,k, 0,0, 0,0);
    add(1,1,0, 55,  0,0, 0,1, 0,0);
    add(0,0,0, 0,   0,0, 0,1, 0,0);

    foreach (tab[i]) begin
      step(tab[i].rst, tab[i].w, tab[i].r, pix_t'(tab[i].d));
      cmp($sformatf("v%0d.dout", i),  32'(dout),  32'(tab[i].ed));
      cmp($sformatf("v%0d.count", i), 32'(count), 32'(tab[i].ec));
      cmp($sformatf("v%0d.full", i),  32'(full),  32'(tab[i].ef));
      cmp($sformatf("v%0d.empty", i), 32'(empty), 32'(tab[i].ee));
      cmp($sformatf("v%0d.ovf", i),   32'(ovf),   32'(tab[i].eo));
      cmp($sformatf("v%0d.udf", i),   32'(udf),   32'(tab[i].eu));
    end

    // pointer wrap at occupancy 3
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, pix_t'(200 + k));
      check_model($sformatf("wrap_fill%0d", k));
    end
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 1, pix_t'(300 + k));
      check_model($sformatf("wrap%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, '0);
      check_model($sformatf("wrap_drain%0d", k));
    end

    // random traffic
    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           pix_t'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
